// File: rtl/bus_bridge_gen_if.sv
// CPU <-> peripheral bus bundle for bus_bridge_gen.
// slave modport is the bridge's view; master is the CPU/peripheral side.
interface bus_bridge_gen_if #(
  parameter int N_DEV = 6
);
  // CPU data port
  logic                  PrReq;
  logic                  PrWe;
  logic [31:0]           PrAddr;
  logic [31:0]           PrWD;
  logic [31:0]           PrRD;
  logic                  PrReady;
  logic                  PrErr;
  // peripheral side
  logic [N_DEV-1:0]      dev_stb;
  logic                  dev_we;
  logic [31:0]           dev_addr;
  logic [31:0]           dev_wd;
  logic [N_DEV*32-1:0]   dev_rd;
  logic [N_DEV-1:0]      dev_ack;
  logic [N_DEV-1:0]      dev_irq;
  logic [5:0]            HWInt;

  modport slave (
    input  PrReq, PrWe, PrAddr, PrWD, dev_rd, dev_ack, dev_irq,
    output PrRD, PrReady, PrErr, dev_stb, dev_we, dev_addr, dev_wd, HWInt
  );

  modport master (
    output PrReq, PrWe, PrAddr, PrWD, dev_rd, dev_ack, dev_irq,
    input  PrRD, PrReady, PrErr, dev_stb, dev_we, dev_addr, dev_wd, HWInt
  );
endinterface

// File: rtl/bus_bridge_gen.sv
// bus_bridge_gen: CPU data port to N_DEV memory-mapped peripherals.
// Address decode against base/size windows (lowest slot wins on overlap),
// IDLE/ACCESS/RESP strobe-ack transaction, per-slot interrupt synchronisers.
// Optional: define BRIDGE_TIMEOUT_EN to abort ACCESS after TIMEOUT cycles
// without ack.

// One interrupt line synchroniser, DEPTH flops deep.
module bus_bridge_gen_sync #(
  parameter int DEPTH = 2
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic d_i,
  output logic q_o
);
  logic [DEPTH-1:0] ff_q;

  // shift the async level through the chain
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) ff_q <= '0;
    else         ff_q <= (ff_q << 1) | DEPTH'(d_i);
  end

  assign q_o = ff_q[DEPTH-1];
endmodule

module bus_bridge_gen #(
  parameter int                  N_DEV      = 6,
  parameter logic [N_DEV*32-1:0] BASE_ADDRS = {32'h7F40, 32'h7F38, 32'h7F34,
                                               32'h7F2C, 32'h7F10, 32'h7F00},
  parameter logic [N_DEV*32-1:0] ADDR_SIZES = {32'h4, 32'h8, 32'h4,
                                               32'h8, 32'h1C, 32'hC},
  parameter int                  TIMEOUT    = 15,
  parameter int                  IRQ_SYNC   = 2
) (
  input logic              clk,
  input logic              reset,
  bus_bridge_gen_if.slave  bus
);
  if (N_DEV < 1 || N_DEV > 6) begin : g_bad_ndev
    $error("bus_bridge_gen: N_DEV must be 1..6");
  end
  if (IRQ_SYNC < 1 || IRQ_SYNC > 3) begin : g_bad_sync
    $error("bus_bridge_gen: IRQ_SYNC must be 1..3");
  end
  if (TIMEOUT < 1) begin : g_bad_to
    $error("bus_bridge_gen: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e           state_q;
  logic [N_DEV-1:0] stb_q;
  logic             we_q;
  logic [31:0]      addr_q, wd_q, rd_q;
  logic             rdy_q, err_q;

  logic [N_DEV-1:0]      win, sel_d;
  logic [N_DEV:0][31:0]  base_acc, rd_acc;

  // Per-slot window hit (33-bit so BASE+SIZE cannot wrap), selected base
  // and read-data mux as OR chains over the one-hot selects.
  assign base_acc[0] = '0;
  assign rd_acc[0]   = '0;
  for (genvar g = 0; g < N_DEV; g++) begin : g_slot
    localparam logic [32:0] LO = {1'b0, BASE_ADDRS[32*g +: 32]};
    localparam logic [32:0] HI = LO + {1'b0, ADDR_SIZES[32*g +: 32]};
    assign win[g]        = ({1'b0, bus.PrAddr} >= LO) && ({1'b0, bus.PrAddr} < HI);
    assign base_acc[g+1] = base_acc[g] | (sel_d[g] ? BASE_ADDRS[32*g +: 32] : 32'h0);
    assign rd_acc[g+1]   = rd_acc[g]   | (stb_q[g] ? bus.dev_rd[32*g +: 32] : 32'h0);
  end

  // isolate lowest set bit: lowest slot index wins on overlap
  assign sel_d = win & (~win + N_DEV'(1));

`ifdef BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
`endif

  // transaction FSM, all outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      stb_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b0;
          err_q <= 1'b0;
          if (bus.PrReq) begin
            we_q <= bus.PrWe;
            wd_q <= bus.PrWD;
            if (|win) begin
              stb_q   <= sel_d;
              addr_q  <= bus.PrAddr - base_acc[N_DEV];
              state_q <= ACCESS;
`ifdef BRIDGE_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end else begin
              // miss: error response next cycle; a missed write leaves PrRD alone
              addr_q  <= bus.PrAddr;
              rdy_q   <= 1'b1;
              err_q   <= 1'b1;
              if (!bus.PrWe) rd_q <= 32'hFFFF_FFFF;
              state_q <= RESP;
            end
          end
        end
        ACCESS: begin
          if (|(bus.dev_ack & stb_q)) begin
            rd_q    <= rd_acc[N_DEV];
            stb_q   <= '0;
            rdy_q   <= 1'b1;
            state_q <= RESP;
          end
`ifdef BRIDGE_TIMEOUT_EN
          // counter would reach TIMEOUT on this edge; an ack above wins
          else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rd_q    <= 32'hFFFF_FFFF;
            stb_q   <= '0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
          end
`endif
        end
        RESP: begin
          rdy_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.PrRD     = rd_q;
  assign bus.PrReady  = rdy_q;
  assign bus.PrErr    = err_q;
  assign bus.dev_stb  = stb_q;
  assign bus.dev_we   = we_q;
  assign bus.dev_addr = addr_q;
  assign bus.dev_wd   = wd_q;

  logic [N_DEV-1:0] irq_s;

  for (genvar g = 0; g < N_DEV; g++) begin : g_irq
    bus_bridge_gen_sync #(.DEPTH(IRQ_SYNC)) u_sync (
      .gclk   (clk),
      .grst_n (reset),
      .d_i    (bus.dev_irq[g]),
      .q_o    (irq_s[g])
    );
  end

  assign bus.HWInt = 6'(irq_s);
endmodule

// File: tb/tb_bus_bridge_gen.sv
// Directed bench for bus_bridge_gen (default parameters).
// Inputs driven on negedge, outputs sampled on negedge after each posedge.
module tb_bus_bridge_gen;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   seen_rdy;

  always #5 clk = ~clk;

  bus_bridge_gen_if #(.N_DEV(6)) bus ();

  bus_bridge_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b0;
    bus.PrReq   = 1'b0;
    bus.PrWe    = 1'b0;
    bus.PrAddr  = '0;
    bus.PrWD    = '0;
    bus.dev_rd  = '0;
    bus.dev_ack = '0;
    bus.dev_irq = '0;
    tick();
    // reset state
    chk("rst_stb",   32'(bus.dev_stb), 32'h0);
    chk("rst_rdy",   32'(bus.PrReady), 32'h0);
    chk("rst_err",   32'(bus.PrErr),   32'h0);
    chk("rst_rd",    bus.PrRD,         32'h0);
    chk("rst_addr",  bus.dev_addr,     32'h0);
    chk("rst_wd",    bus.dev_wd,       32'h0);
    chk("rst_we",    32'(bus.dev_we),  32'h0);
    chk("rst_hwint", 32'(bus.HWInt),   32'h0);
    reset = 1'b1;
    tick();

    // read 0x7F04, slot 0 acks in the first strobe cycle
    bus.dev_rd[0 +: 32] = 32'h1234;
    bus.dev_ack = 6'b000001;
    bus.PrReq = 1'b1; bus.PrWe = 1'b0; bus.PrAddr = 32'h7F04;
    tick();
    bus.PrReq = 1'b0;
    chk("rd0_stb",  32'(bus.dev_stb), 32'h01);
    chk("rd0_addr", bus.dev_addr,     32'h4);
    chk("rd0_we",   32'(bus.dev_we),  32'h0);
    chk("rd0_rdy0", 32'(bus.PrReady), 32'h0);
    tick();
    bus.dev_ack = '0;
    chk("rd0_rdy",  32'(bus.PrReady), 32'h1);
    chk("rd0_err",  32'(bus.PrErr),   32'h0);
    chk("rd0_data", bus.PrRD,         32'h1234);
    chk("rd0_stb0", 32'(bus.dev_stb), 32'h0);
    tick();
    chk("rd0_pulse", 32'(bus.PrReady), 32'h0);

    // write 0x7F34 (slot 3), slot 2 acks throughout and must be ignored
    bus.dev_ack = 6'b000100;
    bus.PrReq = 1'b1; bus.PrWe = 1'b1; bus.PrAddr = 32'h7F34; bus.PrWD = 32'hA5A5;
    tick();
    bus.PrReq = 1'b0;
    chk("wr_stb",  32'(bus.dev_stb), 32'h08);
    chk("wr_we",   32'(bus.dev_we),  32'h1);
    chk("wr_wd",   bus.dev_wd,       32'hA5A5);
    chk("wr_addr", bus.dev_addr,     32'h0);
    tick(); tick(); tick();
    chk("wr_stb_hold", 32'(bus.dev_stb), 32'h08);
    chk("wr_wd_hold",  bus.dev_wd,       32'hA5A5);
    chk("wr_rdy_wait", 32'(bus.PrReady), 32'h0);
    bus.dev_ack = 6'b001000;
    tick();
    bus.dev_ack = '0;
    chk("wr_rdy", 32'(bus.PrReady), 32'h1);
    chk("wr_err", 32'(bus.PrErr),   32'h0);
    chk("wr_stb0", 32'(bus.dev_stb), 32'h0);
    tick();
    chk("wr_pulse", 32'(bus.PrReady), 32'h0);

    // unmapped read 0x8000
    bus.PrReq = 1'b1; bus.PrWe = 1'b0; bus.PrAddr = 32'h8000;
    tick();
    bus.PrReq = 1'b0;
    chk("miss_rdy", 32'(bus.PrReady), 32'h1);
    chk("miss_err", 32'(bus.PrErr),   32'h1);
    chk("miss_rd",  bus.PrRD,         32'hFFFF_FFFF);
    chk("miss_stb", 32'(bus.dev_stb), 32'h0);
    tick();
    chk("miss_pulse", 32'(bus.PrReady), 32'h0);
    chk("miss_err0",  32'(bus.PrErr),   32'h0);

    // window edge: 0x7F0C is one past slot 0 and below slot 1
    bus.PrReq = 1'b1; bus.PrAddr = 32'h7F0C;
    tick();
    bus.PrReq = 1'b0;
    chk("edge_miss", 32'(bus.PrErr), 32'h1);
    tick();

    // last byte of slot 2 window, back-to-back with PrReq held high
    bus.dev_rd[64 +: 32] = 32'hC0DE;
    bus.dev_ack = 6'b000100;
    bus.PrReq = 1'b1; bus.PrAddr = 32'h7F33;
    tick();
    chk("top_stb",  32'(bus.dev_stb), 32'h04);
    chk("top_addr", bus.dev_addr,     32'h7);
    tick();
    chk("top_rd",   bus.PrRD,         32'hC0DE);
    tick();
    chk("b2b_idle", 32'(bus.dev_stb), 32'h0);
    tick();
    chk("b2b_acc",  32'(bus.dev_stb), 32'h04);
    bus.PrReq = 1'b0;
    tick(); tick();
    bus.dev_ack = '0;

    // interrupt pulse on slot 1 for 5 cycles
    bus.dev_irq = 6'b000010;
    tick();
    chk("irq_e1", 32'(bus.HWInt), 32'h0);
    tick();
    chk("irq_e2", 32'(bus.HWInt), 32'h02);
    tick(); tick(); tick();
    chk("irq_e5", 32'(bus.HWInt), 32'h02);
    bus.dev_irq = '0;
    tick();
    chk("irq_e6", 32'(bus.HWInt), 32'h02);
    tick();
    chk("irq_e7", 32'(bus.HWInt), 32'h0);

    // slot 4 (0x7F3C) never acks
    bus.PrReq = 1'b1; bus.PrWe = 1'b0; bus.PrAddr = 32'h7F3C;
    tick();
    bus.PrReq = 1'b0;
    chk("to_stb", 32'(bus.dev_stb), 32'h10);
`ifdef BRIDGE_TIMEOUT_EN
    for (int i = 0; i < 14; i++) tick();
    chk("to_stb14", 32'(bus.dev_stb), 32'h10);
    chk("to_rdy14", 32'(bus.PrReady), 32'h0);
    tick();
    chk("to_rdy", 32'(bus.PrReady), 32'h1);
    chk("to_err", 32'(bus.PrErr),   32'h1);
    chk("to_rd",  bus.PrRD,         32'hFFFF_FFFF);
    chk("to_stb0", 32'(bus.dev_stb), 32'h0);
    tick();
    // start a fresh access to abort with reset
    bus.PrReq = 1'b1; bus.PrAddr = 32'h7F40;
    tick();
    bus.PrReq = 1'b0;
    chk("abort_stb", 32'(bus.dev_stb), 32'h20);
`else
    seen_rdy = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (bus.PrReady) seen_rdy++;
    end
    chk("hang_rdy", 32'(seen_rdy),      32'h0);
    chk("hang_stb", 32'(bus.dev_stb),   32'h10);
`endif

    // reset mid-ACCESS with an interrupt visible
    bus.dev_irq = 6'b000001;
    tick(); tick();
    chk("pre_rst_irq", 32'(bus.HWInt), 32'h01);
    reset = 1'b0;
    #1;
    chk("arst_stb",   32'(bus.dev_stb), 32'h0);
    chk("arst_rdy",   32'(bus.PrReady), 32'h0);
    chk("arst_hwint", 32'(bus.HWInt),   32'h0);
    bus.dev_irq = '0;
    tick();
    chk("arst_rdy_hold", 32'(bus.PrReady), 32'h0);
    reset = 1'b1;
    tick();

    // fresh read of slot 1 after release
    bus.dev_rd[32 +: 32] = 32'h5A5A_0001;
    bus.dev_ack = 6'b000010;
    bus.PrReq = 1'b1; bus.PrAddr = 32'h7F18;
    tick();
    bus.PrReq = 1'b0;
    chk("post_stb",  32'(bus.dev_stb), 32'h02);
    chk("post_addr", bus.dev_addr,     32'h8);
    tick();
    chk("post_rdy",  32'(bus.PrReady), 32'h1);
    chk("post_rd",   bus.PrRD,         32'h5A5A_0001);
    bus.dev_ack = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
